// File: rtl/snake_mbox_pkg.sv
// Register map, status/control bit positions and address-width helper shared
// by the snake command/state mailbox.
package snake_mbox_pkg;

  typedef enum logic [1:0] {
    REG_CMD    = 2'd0,
    REG_STATE  = 2'd1,
    REG_STATUS = 2'd2,
    REG_CTRL   = 2'd3
  } mbox_reg_e;

  localparam int STS_FULL    = 0;
  localparam int STS_EMPTY   = 1;
  localparam int STS_OVF     = 2;
  localparam int STS_NEW     = 3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  function automatic int mbox_addr_w(input int num_ch);
    return 2 + $clog2(num_ch);
  endfunction

endpackage

// File: rtl/snake_mbox_fifo.sv
// Show-ahead command FIFO for one mailbox channel; flush empties it and
// overrides any push or pop issued in the same cycle.
module snake_mbox_fifo #(
  parameter int  W     = 7,
  parameter int  DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  // A push into a full FIFO is still accepted when a pop frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/snake_cmd_mailbox.sv
// Multi-channel HPS<->game command/state mailbox on an Avalon-MM slave.
// Define SNAKE_MBOX_IRQ_EN to build the per-channel irq_en bit and irq output.
module snake_cmd_mailbox
  import snake_mbox_pkg::*;
#(
  parameter int  NUM_CH  = 2,
  parameter int  CMD_W   = 7,
  parameter int  STATE_W = 7,
  parameter int  DEPTH   = 8,
  localparam int AW      = mbox_addr_w(NUM_CH),
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [AW-1:0]             avs_address,
  input  logic                      avs_write,
  input  logic [31:0]               avs_writedata,
  input  logic                      avs_read,
  output logic [31:0]               avs_readdata,
  output logic [NUM_CH-1:0]         cmd_valid,
  input  logic [NUM_CH-1:0]         cmd_ready,
  output logic [NUM_CH*CMD_W-1:0]   cmd_data,
  input  logic [NUM_CH-1:0]         state_we,
  input  logic [NUM_CH*STATE_W-1:0] state_data
`ifdef SNAKE_MBOX_IRQ_EN
  ,
  output logic                      irq
`endif
);

  mbox_reg_e          reg_sel;
  logic [31:0]        ch_sel;
  logic [NUM_CH-1:0]  wr_hit, rd_hit;
  logic [NUM_CH-1:0]  push, pop, flush, full, empty;
  logic [CMD_W-1:0]   head  [NUM_CH];
  logic [CNT_W-1:0]   count [NUM_CH];

  logic [NUM_CH-1:0]  en_q, en_d;
  logic [NUM_CH-1:0]  new_q, new_d;
  logic [NUM_CH-1:0]  ovf_q, ovf_d;
  logic [STATE_W-1:0] state_q [NUM_CH];
  logic [STATE_W-1:0] state_d [NUM_CH];
  logic [31:0]        readdata_q, readdata_d, rd_word;
  logic               unused_wdata;

`ifdef SNAKE_MBOX_IRQ_EN
  logic [NUM_CH-1:0]  irq_en_q, irq_en_d;
  logic               irq_q, irq_d;
`endif

  assign reg_sel      = mbox_reg_e'(avs_address[1:0]);
  assign ch_sel       = 32'(avs_address) >> 2;
  assign unused_wdata = ^avs_writedata;
  assign avs_readdata = readdata_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    snake_mbox_fifo #(
      .W     (CMD_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push[c]),
      .pop     (pop[c]),
      .flush   (flush[c]),
      .wdata   (avs_writedata[CMD_W-1:0]),
      .head    (head[c]),
      .full    (full[c]),
      .empty   (empty[c]),
      .count   (count[c])
    );

    assign cmd_valid[c]                = en_q[c] & ~empty[c];
    assign pop[c]                      = cmd_valid[c] & cmd_ready[c];
    assign cmd_data[c*CMD_W +: CMD_W]  = cmd_valid[c] ? head[c] : '0;
  end

  always_comb begin
    wr_hit  = '0;
    rd_hit  = '0;
    push    = '0;
    flush   = '0;
    en_d    = en_q;
    new_d   = new_q;
    ovf_d   = ovf_q;
    state_d = state_q;
`ifdef SNAKE_MBOX_IRQ_EN
    irq_en_d = irq_en_q;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      wr_hit[c] = avs_write && (ch_sel == 32'(c));
      rd_hit[c] = avs_read  && (ch_sel == 32'(c));
      push[c]   = wr_hit[c] && (reg_sel == REG_CMD) && en_q[c];

      if (push[c] && full[c] && !pop[c]) ovf_d[c] = 1'b1;
      if (wr_hit[c] && (reg_sel == REG_STATUS) && avs_writedata[STS_OVF]) ovf_d[c] = 1'b0;

      if (wr_hit[c] && (reg_sel == REG_CTRL)) begin
        en_d[c] = avs_writedata[CTRL_EN];
`ifdef SNAKE_MBOX_IRQ_EN
        irq_en_d[c] = avs_writedata[CTRL_IRQ_EN];
`endif
      end
      // Flushing on the next enable value empties the FIFO in the very cycle it is disabled.
      flush[c] = !en_d[c];

      if (rd_hit[c] && (reg_sel == REG_STATE)) new_d[c] = 1'b0;
      if (state_we[c]) begin
        state_d[c] = state_data[c*STATE_W +: STATE_W];
        new_d[c]   = 1'b1;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel == 32'(c)) begin
        case (reg_sel)
          REG_CMD:    rd_word = 32'(count[c]);
          REG_STATE:  rd_word = 32'(state_q[c]);
          REG_STATUS: begin
            rd_word[STS_FULL]  = full[c];
            rd_word[STS_EMPTY] = empty[c];
            rd_word[STS_OVF]   = ovf_q[c];
            rd_word[STS_NEW]   = new_q[c];
          end
          REG_CTRL: begin
            rd_word[CTRL_EN] = en_q[c];
`ifdef SNAKE_MBOX_IRQ_EN
            rd_word[CTRL_IRQ_EN] = irq_en_q[c];
`endif
          end
          default: rd_word = '0;
        endcase
      end
    end
    readdata_d = avs_read ? rd_word : '0;
  end

`ifdef SNAKE_MBOX_IRQ_EN
  assign irq_d = |(new_q & irq_en_q & en_q);
  assign irq   = irq_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      en_q       <= '1;
      new_q      <= '0;
      ovf_q      <= '0;
      for (int c = 0; c < NUM_CH; c++) state_q[c] <= '0;
      readdata_q <= '0;
`ifdef SNAKE_MBOX_IRQ_EN
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
`endif
    end else begin
      en_q       <= en_d;
      new_q      <= new_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      readdata_q <= readdata_d;
`ifdef SNAKE_MBOX_IRQ_EN
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
`endif
    end
  end

endmodule

// File: doc/snake_cmd_mailbox.md
# snake_cmd_mailbox

Multi-channel command/state mailbox between the HPS (lightweight Avalon-MM slave) and the snake game fabric logic. It generalises the single 7-bit command/state conduit pair into NUM_CH independent channels, each with a DEPTH-entry command FIFO (HPS → game) and a latched state word with a new-data flag (game → HPS). Every channel also has sticky overflow status. It sits in the Computer_System fabric between the HPS-to-FPGA lightweight bridge and the game cores.

## Interface
Parameters:
- NUM_CH, 2: number of channels (1..4).
- CMD_W, 7: command width (1..32).
- STATE_W, 7: state word width (1..32).
- DEPTH, 8: command FIFO depth per channel (power of 2, ≥2).

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  synchronous, active-low reset.
- avs_address  in  2+clog2(NUM_CH)  {channel, reg[1:0]}.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  registered read data.
- cmd_valid  out  NUM_CH  per-channel FIFO non-empty.
- cmd_ready  in  NUM_CH  per-channel pop.
- cmd_data  out  NUM_CH*CMD_W  per-channel FIFO head (show-ahead), channel c at [c*CMD_W +: CMD_W].
- state_we  in  NUM_CH  per-channel state write strobe.
- state_data  in  NUM_CH*STATE_W  per-channel state word.
- irq  out  1  present only with SNAKE_MBOX_IRQ_EN.

## Operation
Registers per channel:
- reg0 CMD: write pushes writedata[CMD_W-1:0]. Read returns fill count, zero-extended.
- reg1 STATE: read returns latched state, zero-extended. The read clears state_new.
- reg2 STATUS: bit0 full, bit1 empty, bit2 overflow (sticky; write 1 to clear), bit3 state_new. Other bits read 0.
- reg3 CTRL: bit0 enable (reset 1), bit1 irq_en (reset 0).

Channel behaviour:
- Disabled channel: pushes are ignored (no overflow), cmd_valid is forced 0, and the FIFO is flushed to empty while enable=0.
- Channel index ≥ NUM_CH: writes are ignored and reads return 0.

FIFO:
- Pop on cmd_valid & cmd_ready.
- Push on a full FIFO with no pop in the same cycle: data is dropped and overflow is set.
- Push and pop in the same cycle on a full FIFO: push is accepted and the count is unchanged.
- Push and pop in the same cycle on a non-full, non-empty FIFO: count is unchanged.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Count is clog2(DEPTH)+1 bits.

State path:
- state_we latches the state word and sets state_new.
- If state_we coincides with a HPS read of reg1: readdata returns the old value and state_new stays 1 (the set wins).

Write to CTRL.enable=0 in the same cycle as a push to that channel: the flush wins and the FIFO ends empty.

## Timing
- Avalon slave, no waitrequest. Writes take effect on the clock edge. readdata is valid the cycle after avs_read (fixed read latency 1).
- Push-to-cmd_valid latency: 1 cycle. cmd_data is valid combinationally from the head while cmd_valid=1.
- state_we to STATUS.bit3 visible: next cycle.
- Reset values: avs_readdata 0, cmd_valid 0, cmd_data 0, irq 0. Per channel: count 0, pointers 0, state 0, state_new 0, overflow 0, enable 1, irq_en 0.
- Reset mid-operation discards all queued commands. There is no partial pop.

## Configuration
- SNAKE_MBOX_IRQ_EN defined:
  - irq port exists: registered OR over channels of (state_new & irq_en & enable). Asserts 1 cycle after state_new sets.
  - irq deasserts 1 cycle after the clearing read of reg1 or after irq_en is cleared.
- Undefined: no irq port, CTRL.bit1 is not stored and reads 0, and no interrupt logic is built.

## Structure
- Package snake_mbox_pkg holds:
  - register offsets: REG_CMD=0, REG_STATE=1, REG_STATUS=2, REG_CTRL=3;
  - STATUS/CTRL bit positions;
  - the function computing the address width.
- Sub-module snake_mbox_fifo: parametrised by width and depth, with push, pop, flush, full, empty and count outputs. It is instantiated once per channel via generate. The top level holds the decode, state latches, status and readback mux.

## Test plan
- NUM_CH=2, DEPTH=8: write 0x11, 0x22, 0x33 to ch1 reg0 with cmd_ready=0 → cmd_valid=2'b10, ch1 head 0x11, ch1 count reads 3. Pulse cmd_ready[1] three times → heads 0x22, 0x33, then cmd_valid[1]=0.
- Push 9 commands to ch0 without popping → entries 1..8 kept, STATUS=0x5 (full and overflow). Write 0x4 to STATUS → overflow clears, full remains.
- Ch0 full, push 0x7F with cmd_ready[0]=1 in the same cycle → count stays 8 and 0x7F becomes the tail (read out last after 8 pops).
- state_we[1] with 0x2A → STATUS.bit3=1 and reg1 reads 0x2A. Read reg1 again in the same cycle as state_we with 0x15 → readdata 0x2A, state_new stays 1, next read 0x15.
- With SNAKE_MBOX_IRQ_EN: set ch0 irq_en, state_we[0] → irq=1 next cycle. Read reg1 → irq=0 one cycle after.
- Reset asserted with 5 entries queued and enable=0 → all counts 0, cmd_valid 0, enable reads 1 after release.
